sdram_slot_arbiter: RTL and testbench
=====================================

# sdram_slot_arbiter

Shares the single byte-wide SDRAM port between the CPU/gate-array memory interface and the ROM download loader. Accesses are issued only on `ce_ref` slot boundaries. ROM pages from the download stream are remapped onto the fixed ROM bank layout, and reads from unpopulated ROM banks float high. It sits between the motherboard memory bus, the hps_io download channel, and zsdram, and replaces the ad-hoc reset-time muxing and boot write handshake.

## Interface
Parameters:
- `SLOT_LEN`, default 16: clk_sys cycles between `ce_ref` pulses; sizes the stall watchdog.

Ports:
- `clk_sys` in 1: system clock.
- `RESET_n` in 1: asynchronous, active-low reset.
- `ce_ref` in 1: one-cycle SDRAM slot strobe.
- `cpu_rd`, `cpu_wr` in 1: CPU read/write request levels.
- `cpu_a` in 23: CPU SDRAM address.
- `cpu_din` in 8: CPU write data.
- `cpu_dout` out 8: read data, OR'd with the ROM mask.
- `ldr_active` in 1: download in progress; gives the loader ownership of the port.
- `ldr_req` in 1: one-cycle strobe, loader byte valid.
- `ldr_a` in 25: download byte address.
- `ldr_din` in 8: download byte.
- `ldr_ack` out 1: one-cycle pulse, byte consumed (written or dropped).
- `ram_oe`, `ram_we` out 1: zsdram read/write enables.
- `ram_addr` out 23: zsdram address.
- `ram_din` out 8: zsdram write data.
- `ram_dout` in 8: zsdram read data.
- `ldr_count` out 16: bytes written this download, saturating.
- `ldr_drop` out 1: sticky flag, a byte fell outside the mapped pages.

## Operation
- **Owner select:** `owner` is LDR while `ldr_active`=1, else CPU.
  - `owner` changes only in IDLE, or when a slot ends.
  - An in-flight slot always completes before ownership changes.
- **States:**
  - IDLE: no access.
  - LDR_PEND: byte latched, waiting for `ce_ref`.
  - LDR_WR: write slot active.
  - CPU_ACC: CPU slot active.
- **Loader path:**
  - `ldr_req` in IDLE with owner LDR latches `ldr_a`/`ldr_din`, then enters LDR_PEND.
  - Page map on `ldr_a[24:14]`: 0→0x000, 1→0x100, 2→0x107. Any other page is dropped: `ldr_ack` pulses on the next cycle, `ldr_drop` is set, no SDRAM access, return to IDLE.
  - `ram_addr` = {mapped page, `ldr_a[13:0]`}.
  - On `ce_ref` in LDR_PEND: `ram_we`=1, enter LDR_WR.
  - On the next `ce_ref`: `ram_we`=0, `ldr_ack` pulses, `ldr_count`++ (saturates at 0xFFFF), return to IDLE.
  - `ldr_req` outside IDLE is ignored; the loader must wait for `ldr_ack`.
- **CPU path:**
  - On `ce_ref` in IDLE with owner CPU and (`cpu_rd`|`cpu_wr`): latch `cpu_a`/`cpu_din`, drive `ram_oe`=`cpu_rd` and `ram_we`=`cpu_wr & ~cpu_rd` (read wins), enter CPU_ACC.
  - On the next `ce_ref`: capture `ram_dout` into the read register if a read, drop enables, and re-evaluate the request in the same cycle. A held request therefore gets back-to-back slots.
- **ROM mask:** computed from the latched CPU address page. It is 0x00 for pages 0x000–0x0FF, 0x100 and 0x107, and 0xFF otherwise. `cpu_dout` = read register | mask.
- **Counters:** `ldr_count` and `ldr_drop` clear on the rising edge of `ldr_active`.
- **Watchdog:** if LDR_PEND lasts more than 2×`SLOT_LEN` cycles without `ce_ref`, return to IDLE without writing and without acking.

## Timing
- **Reset values:** all outputs 0, except `cpu_dout`=0xFF (mask 0xFF).
  - State IDLE, owner CPU, counters 0.
  - Reset asserted mid-slot aborts immediately; no `ldr_ack` is issued.
- **Registers:** all enables and address/data outputs are registered and change only on the cycle after `ce_ref`, or after a loader latch.
- **Loader latency:** `ldr_req` to `ldr_ack` is between 1×`SLOT_LEN` and 2×`SLOT_LEN`+2 cycles.
- **Dropped bytes:** `ldr_req` to `ldr_ack` is exactly 1 cycle.
- **CPU read latency:** read data is valid the cycle after the slot-ending `ce_ref` and holds until the next read completes.
- **Simultaneous `ce_ref` and `ldr_req` in IDLE:** the latch happens this cycle; the write waits for the next `ce_ref`.
- **`ldr_active` falling during LDR_PEND:** the pending write still completes and acks.

## Test plan
- **Loader write, page 1:** `ldr_active`=1, `ldr_req` with `ldr_a`=0x04005, `ldr_din`=0x5A → `ram_we` for one slot with `ram_addr`=0x400005 and `ram_din`=0x5A; then `ldr_ack` pulse and `ldr_count`=1.
- **Drop, page 3:** `ldr_a`=0x0C000 → `ldr_ack` the next cycle; `ram_we` never asserts; `ldr_drop`=1.
- **CPU read of unmapped page:** `cpu_rd` with `cpu_a`=0x410000 and `ram_dout`=0x12 → `cpu_dout`=0xFF. With `cpu_a`=0x001234 → `cpu_dout`=0x12.
- **Handover:** `ldr_active` falls during LDR_PEND → the write completes with an ack, then the next CPU request is served on the following slot.
- **Reset mid-write:** assert `RESET_n`=0 during LDR_WR → `ram_we`=0 immediately, no ack, state IDLE after release.
- **Back-to-back CPU reads:** `cpu_rd` held for 4 slots → `ram_oe` high continuously, 4 data captures, each matching `ram_dout` at its slot end.

Source files
------------

// File: rtl/sdram_slot_arbiter.sv
// Slot-based arbiter sharing the byte-wide SDRAM port between the CPU bus and the ROM
// download loader; remaps loader pages onto the ROM bank layout and masks unpopulated banks.
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | no access in flight, ownership may change
// LDR_PEND | loader byte latched, waiting for a slot strobe
// LDR_WR   | loader write slot active
// CPU_ACC  | CPU read or write slot active
module sdram_slot_arbiter #(
    parameter int SLOT_LEN = 16
) (
    input  logic        clk_sys,
    input  logic        RESET_n,
    input  logic        ce_ref,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [22:0] cpu_a,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    input  logic        ldr_active,
    input  logic        ldr_req,
    input  logic [24:0] ldr_a,
    input  logic [7:0]  ldr_din,
    output logic        ldr_ack,
    output logic        ram_oe,
    output logic        ram_we,
    output logic [22:0] ram_addr,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    output logic [15:0] ldr_count,
    output logic        ldr_drop
);

    localparam int WD_MAX = 2 * SLOT_LEN;
    localparam int WD_W   = $clog2(WD_MAX + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LDR_PEND = 2'd1,
        LDR_WR   = 2'd2,
        CPU_ACC  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              ram_oe_d, ram_we_d;
    logic [22:0]       ram_addr_d;
    logic [7:0]        ram_din_d;
    logic              ldr_ack_d;
    logic [15:0]       ldr_count_d;
    logic              ldr_drop_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [7:0]        rom_mask_q, rom_mask_d;
    logic [8:0]        cpu_page_q, cpu_page_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              ldr_active_q;
    logic              cpu_req;
    logic              start_cpu;
    logic              ldr_page_ok;
    logic [8:0]        ldr_page_base;

    // Banks 0x000-0x0FF are RAM, 0x100 and 0x107 hold ROM images; everything else floats high.
    function automatic logic [7:0] rom_mask_of(input logic [8:0] page);
        if (!page[8] || page == 9'h100 || page == 9'h107)
            return 8'h00;
        return 8'hFF;
    endfunction

    assign cpu_req  = cpu_rd | cpu_wr;
    assign cpu_dout = rd_data_q | rom_mask_q;

    always_comb begin
        ldr_page_ok   = 1'b1;
        ldr_page_base = 9'h000;
        case (ldr_a[24:14])
            11'd0:   ldr_page_base = 9'h000;
            11'd1:   ldr_page_base = 9'h100;
            11'd2:   ldr_page_base = 9'h107;
            default: ldr_page_ok   = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ram_oe_d   = ram_oe;
        ram_we_d   = ram_we;
        ram_addr_d = ram_addr;
        ram_din_d  = ram_din;
        ldr_ack_d  = 1'b0;
        rd_data_d  = rd_data_q;
        rom_mask_d = rom_mask_q;
        cpu_page_d = cpu_page_q;
        wd_d       = wd_q;
        start_cpu  = 1'b0;

        if (ldr_active && !ldr_active_q) begin
            ldr_count_d = '0;
            ldr_drop_d  = 1'b0;
        end else begin
            ldr_count_d = ldr_count;
            ldr_drop_d  = ldr_drop;
        end

        case (state_q)
            IDLE: begin
                if (ldr_active) begin
                    if (ldr_req) begin
                        if (ldr_page_ok) begin
                            ram_addr_d = {ldr_page_base, ldr_a[13:0]};
                            ram_din_d  = ldr_din;
                            wd_d       = WD_W'(WD_MAX);
                            state_d    = LDR_PEND;
                        end else begin
                            ldr_ack_d  = 1'b1;
                            ldr_drop_d = 1'b1;
                        end
                    end
                end else if (ce_ref && cpu_req) begin
                    start_cpu = 1'b1;
                end
            end
            LDR_PEND: begin
                if (ce_ref) begin
                    ram_we_d = 1'b1;
                    state_d  = LDR_WR;
                end else if (wd_q == '0) begin
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q - WD_W'(1);
                end
            end
            LDR_WR: begin
                if (ce_ref) begin
                    ram_we_d  = 1'b0;
                    ldr_ack_d = 1'b1;
                    if (ldr_count_d != 16'hFFFF)
                        ldr_count_d = ldr_count_d + 16'd1;
                    state_d = IDLE;
                end
            end
            CPU_ACC: begin
                if (ce_ref) begin
                    if (ram_oe) begin
                        rd_data_d  = ram_dout;
                        rom_mask_d = rom_mask_of(cpu_page_q);
                    end
                    ram_oe_d = 1'b0;
                    ram_we_d = 1'b0;
                    state_d  = IDLE;
                    // A held request rolls straight into the next slot unless the loader took over.
                    if (!ldr_active && cpu_req)
                        start_cpu = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_cpu) begin
            ram_addr_d = cpu_a;
            ram_din_d  = cpu_din;
            cpu_page_d = cpu_a[22:14];
            ram_oe_d   = cpu_rd;
            ram_we_d   = cpu_wr & ~cpu_rd;
            state_d    = CPU_ACC;
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q      <= IDLE;
            ram_oe       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_din      <= '0;
            ldr_ack      <= 1'b0;
            ldr_count    <= '0;
            ldr_drop     <= 1'b0;
            rd_data_q    <= '0;
            rom_mask_q   <= 8'hFF;
            cpu_page_q   <= '0;
            wd_q         <= '0;
            ldr_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ram_oe       <= ram_oe_d;
            ram_we       <= ram_we_d;
            ram_addr     <= ram_addr_d;
            ram_din      <= ram_din_d;
            ldr_ack      <= ldr_ack_d;
            ldr_count    <= ldr_count_d;
            ldr_drop     <= ldr_drop_d;
            rd_data_q    <= rd_data_d;
            rom_mask_q   <= rom_mask_d;
            cpu_page_q   <= cpu_page_d;
            wd_q         <= wd_d;
            ldr_active_q <= ldr_active;
        end
    end

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Bench for sdram_slot_arbiter: emulated SDRAM behind the port, a transaction-level memory
// model for expected read data, directed corner cases and randomized loader/CPU traffic.
module tb_sdram_slot_arbiter;

    localparam int S = 16;

    logic        clk_sys = 1'b0;
    logic        RESET_n;
    logic        ce_ref;
    logic        cpu_rd, cpu_wr;
    logic [22:0] cpu_a;
    logic [7:0]  cpu_din, cpu_dout;
    logic        ldr_active, ldr_req;
    logic [24:0] ldr_a;
    logic [7:0]  ldr_din;
    logic        ldr_ack;
    logic        ram_oe, ram_we;
    logic [22:0] ram_addr;
    logic [7:0]  ram_din, ram_dout;
    logic [15:0] ldr_count;
    logic        ldr_drop;

    sdram_slot_arbiter #(.SLOT_LEN(S)) dut (
        .clk_sys   (clk_sys),
        .RESET_n   (RESET_n),
        .ce_ref    (ce_ref),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_a     (cpu_a),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .ldr_active(ldr_active),
        .ldr_req   (ldr_req),
        .ldr_a     (ldr_a),
        .ldr_din   (ldr_din),
        .ldr_ack   (ldr_ack),
        .ram_oe    (ram_oe),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ldr_count (ldr_count),
        .ldr_drop  (ldr_drop)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_total = 0;
    int          n_bad = 0;
    int          ce_ph = 0;
    bit          ce_en = 1'b1;
    int          ack_cnt = 0;
    int          we_cnt = 0;
    logic [7:0]  emu_mem [int];
    logic [7:0]  ref_mem [int];
    int          exp_count = 0;
    bit          exp_drop = 1'b0;
    int          pool [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Power-up SDRAM contents, shared by the emulator and the model.
    function automatic logic [7:0] init_byte(input logic [22:0] a);
        return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]};
    endfunction

    function automatic logic [7:0] emu_rd(input logic [22:0] a);
        return emu_mem.exists(int'(a)) ? emu_mem[int'(a)] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [22:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(a);
    endfunction

    function automatic logic [7:0] rom_mask(input logic [22:0] a);
        int page;
        page = int'(a) / 16384;
        return (page < 256 || page == 256 || page == 263) ? 8'h00 : 8'hFF;
    endfunction

    // SDRAM word index a loader address lands on, or -1 when the page is not mapped.
    function automatic int ldr_target(input logic [24:0] la);
        int page;
        int base;
        page = int'(la) / 16384;
        case (page)
            0: base = 0;
            1: base = 256;
            2: base = 263;
            default: return -1;
        endcase
        return base * 16384 + int'(la) % 16384;
    endfunction

    task automatic preload(input logic [22:0] a, input logic [7:0] d);
        emu_mem[int'(a)] = d;
        ref_mem[int'(a)] = d;
    endtask

    task automatic tick();
        if (ram_we && ce_ref)
            emu_mem[int'(ram_addr)] = ram_din;
        @(posedge clk_sys);
        #1;
        if (ldr_ack) ack_cnt++;
        if (ram_we) we_cnt++;
        ce_ref = ce_en && (ce_ph == S - 1);
        ce_ph = (ce_ph + 1) % S;
        ram_dout = emu_rd(ram_addr);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ldr_byte(input logic [24:0] a, input logic [7:0] d, output int lat,
                            output int wcyc, output logic [22:0] wa, output logic [7:0] wd);
        int a0;
        a0 = ack_cnt;
        wcyc = 0;
        wa = '0;
        wd = '0;
        ldr_a = a;
        ldr_din = d;
        ldr_req = 1'b1;
        tick();
        ldr_req = 1'b0;
        lat = 1;
        while (ack_cnt == a0 && lat < 3 * S + 4) begin
            if (ram_we) begin
                wcyc++;
                wa = ram_addr;
                wd = ram_din;
            end
            tick();
            lat++;
        end
    endtask

    task automatic cpu_op(input bit wr, input logic [22:0] a, input logic [7:0] dat,
                          output logic [7:0] rdata);
        int n;
        cpu_a = a;
        cpu_din = dat;
        cpu_rd = !wr;
        cpu_wr = wr;
        n = 0;
        while (!(ram_oe || ram_we) && n < S + 2) begin
            tick();
            n++;
        end
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        check_eq("cpu_slot_start", 32'(ram_oe || ram_we), 32'd1);
        check_eq("cpu_slot_addr", 32'(ram_addr), 32'(a));
        check_eq("cpu_slot_kind", 32'({ram_oe, ram_we}), wr ? 32'd1 : 32'd2);
        n = 0;
        while ((ram_oe || ram_we) && n < S + 2) begin
            tick();
            n++;
        end
        check_eq("cpu_slot_len", 32'(n), 32'(S));
        rdata = cpu_dout;
    endtask

    int          lat, wc, n, a0, w0, tgt, page, nb;
    logic [22:0] wa, ca;
    logic [7:0]  wd, rdata, d;
    logic [24:0] la;
    logic [7:0]  v [4];
    bit          early, cont, wr;

    initial begin
        RESET_n = 1'b0;
        ce_ref = 1'b0;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        cpu_a = '0;
        cpu_din = '0;
        ldr_active = 1'b0;
        ldr_req = 1'b0;
        ldr_a = '0;
        ldr_din = '0;
        ram_dout = '0;
        ticks(3);
        check_eq("rst_cpu_dout", 32'(cpu_dout), 32'hFF);
        check_eq("rst_enables", 32'({ram_oe, ram_we, ldr_ack, ldr_drop}), 32'd0);
        check_eq("rst_addr_data", 32'({ram_addr, ram_din}), 32'd0);
        check_eq("rst_count", 32'(ldr_count), 32'd0);
        RESET_n = 1'b1;
        ticks(2);

        // Loader byte into page 1.
        ldr_active = 1'b1;
        ticks(2);
        ldr_byte(25'h04005, 8'h5A, lat, wc, wa, wd);
        check_eq("ldr_p1_addr", 32'(wa), 32'h400005);
        check_eq("ldr_p1_data", 32'(wd), 32'h5A);
        check_eq("ldr_p1_we_len", 32'(wc), 32'(S));
        check_eq("ldr_p1_lat_ok", 32'(lat >= S && lat <= 2 * S + 2), 32'd1);
        check_eq("ldr_p1_count", 32'(ldr_count), 32'd1);
        ref_mem[32'h400005] = 8'h5A;

        // Dropped byte on page 3.
        ldr_byte(25'h0C000, 8'hC3, lat, wc, wa, wd);
        check_eq("drop_lat", 32'(lat), 32'd1);
        check_eq("drop_no_we", 32'(wc), 32'd0);
        check_eq("drop_flag", 32'(ldr_drop), 32'd1);
        check_eq("drop_count", 32'(ldr_count), 32'd1);

        // CPU reads: unmapped page floats high, RAM page returns data.
        ldr_active = 1'b0;
        ticks(2);
        preload(23'h410000, 8'h12);
        cpu_op(1'b0, 23'h410000, 8'h00, rdata);
        check_eq("rd_unmapped", 32'(rdata), 32'hFF);
        preload(23'h001234, 8'h12);
        cpu_op(1'b0, 23'h001234, 8'h00, rdata);
        check_eq("rd_ram", 32'(rdata), 32'h12);

        // Handover: loader drops active while its byte is pending.
        ldr_active = 1'b1;
        ticks(2);
        a0 = ack_cnt;
        ldr_a = 25'h00077;
        ldr_din = 8'hA5;
        ldr_req = 1'b1;
        tick();
        ldr_req = 1'b0;
        ldr_active = 1'b0;
        cpu_a = 23'h000077;
        cpu_rd = 1'b1;
        early = 1'b0;
        n = 0;
        while (ack_cnt == a0 && n < 3 * S) begin
            if (ram_oe) early = 1'b1;
            tick();
            n++;
        end
        check_eq("ho_ack", 32'(ack_cnt - a0), 32'd1);
        check_eq("ho_no_early_cpu", 32'(early), 32'd0);
        check_eq("ho_count", 32'(ldr_count), 32'd1);
        n = 0;
        while (!ram_oe && n < S + 2) begin
            tick();
            n++;
        end
        check_eq("ho_cpu_next_slot", 32'(n), 32'(S));
        cpu_rd = 1'b0;
        n = 0;
        while (ram_oe && n < S + 2) begin
            tick();
            n++;
        end
        ref_mem[32'h77] = 8'hA5;
        check_eq("ho_rd_data", 32'(cpu_dout), 32'(ref_rd(23'h77) | rom_mask(23'h77)));

        // Reset in the middle of a loader write slot.
        ldr_active = 1'b1;
        ticks(2);
        ldr_a = 25'h08010;
        ldr_din = 8'h3C;
        ldr_req = 1'b1;
        tick();
        ldr_req = 1'b0;
        n = 0;
        while (!ram_we && n < 2 * S + 2) begin
            tick();
            n++;
        end
        check_eq("rst_mid_we_seen", 32'(ram_we), 32'd1);
        ticks(3);
        a0 = ack_cnt;
        RESET_n = 1'b0;
        ldr_active = 1'b0;
        #1;
        check_eq("rst_mid_we_drop", 32'(ram_we), 32'd0);
        ticks(3);
        RESET_n = 1'b1;
        ticks(2);
        check_eq("rst_mid_no_ack", 32'(ack_cnt - a0), 32'd0);
        check_eq("rst_mid_count", 32'(ldr_count), 32'd0);
        cpu_op(1'b0, 23'h41C010, 8'h00, rdata);
        check_eq("rst_mid_not_written", 32'(rdata), 32'(ref_rd(23'h41C010) | rom_mask(23'h41C010)));

        // Held CPU read for four slots.
        ca = 23'h0012AB;
        for (int i = 0; i < 4; i++) v[i] = 8'($urandom);
        preload(ca, v[0]);
        cpu_a = ca;
        cpu_rd = 1'b1;
        n = 0;
        while (!ram_oe && n < S + 2) begin
            tick();
            n++;
        end
        cont = ram_oe;
        for (int k = 0; k < 4; k++) begin
            for (int t = 1; t <= S; t++) begin
                tick();
                if (t < S && !ram_oe) cont = 1'b0;
            end
            check_eq("b2b_data", 32'(cpu_dout), 32'(v[k] | rom_mask(ca)));
            if (k < 3) begin
                if (!ram_oe) cont = 1'b0;
                preload(ca, v[k+1]);
            end
            if (k == 2) cpu_rd = 1'b0;
        end
        check_eq("b2b_oe_continuous", 32'(cont), 32'd1);
        check_eq("b2b_oe_released", 32'(ram_oe), 32'd0);

        // Watchdog: no slot strobes while a loader byte is pending.
        ldr_active = 1'b1;
        ticks(2);
        ce_en = 1'b0;
        tick();
        a0 = ack_cnt;
        w0 = we_cnt;
        ldr_a = 25'h00100;
        ldr_din = 8'h99;
        ldr_req = 1'b1;
        tick();
        ldr_req = 1'b0;
        ticks(2 * S + 4);
        ce_en = 1'b1;
        ticks(2 * S + 2);
        check_eq("wd_no_ack", 32'(ack_cnt - a0), 32'd0);
        check_eq("wd_no_we", 32'(we_cnt - w0), 32'd0);
        check_eq("wd_count", 32'(ldr_count), 32'd0);
        ldr_active = 1'b0;
        ticks(2);
        cpu_op(1'b0, 23'h000100, 8'h00, rdata);
        check_eq("wd_not_written", 32'(rdata), 32'(ref_rd(23'h100) | rom_mask(23'h100)));

        // Randomized loader bursts followed by CPU traffic.
        for (int r = 0; r < 6; r++) begin
            ldr_active = 1'b1;
            ticks(2);
            exp_count = 0;
            exp_drop = 1'b0;
            nb = $urandom_range(2, 5);
            for (int b = 0; b < nb; b++) begin
                ticks($urandom_range(0, S));
                page = $urandom_range(0, 4);
                la = 25'(page * 16384 + int'($urandom_range(0, 16383)));
                d = 8'($urandom);
                tgt = ldr_target(la);
                ldr_byte(la, d, lat, wc, wa, wd);
                if (tgt < 0) begin
                    check_eq("rnd_drop_lat", 32'(lat), 32'd1);
                    check_eq("rnd_drop_we", 32'(wc), 32'd0);
                    exp_drop = 1'b1;
                end else begin
                    check_eq("rnd_ldr_lat_ok", 32'(lat >= S && lat <= 2 * S + 2), 32'd1);
                    check_eq("rnd_ldr_we_len", 32'(wc), 32'(S));
                    check_eq("rnd_ldr_addr", 32'(wa), 32'(tgt));
                    check_eq("rnd_ldr_data", 32'(wd), 32'(d));
                    ref_mem[tgt] = d;
                    exp_count++;
                    pool.push_back(tgt);
                end
            end
            check_eq("rnd_count", 32'(ldr_count), 32'(exp_count));
            check_eq("rnd_drop", 32'(ldr_drop), 32'(exp_drop));
            ldr_active = 1'b0;
            ticks(2);
            for (int m = 0; m < 6; m++) begin
                ticks($urandom_range(0, S));
                case ($urandom_range(0, 2))
                    0: ca = (pool.size() > 0) ? 23'(pool[$urandom_range(0, pool.size() - 1)])
                                              : 23'($urandom_range(0, 32'h3FFFFF));
                    1: ca = 23'($urandom_range(0, 32'h3FFFFF));
                    default: ca = 23'($urandom);
                endcase
                wr = ($urandom_range(0, 3) == 0);
                d = 8'($urandom);
                cpu_op(wr, ca, d, rdata);
                if (wr) begin
                    ref_mem[int'(ca)] = d;
                    pool.push_back(int'(ca));
                end else begin
                    check_eq("rnd_cpu_rd", 32'(rdata), 32'(ref_rd(ca) | rom_mask(ca)));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
